// File: rtl/fp_pkg.sv
// Shared FP16 definitions: op encodings, field positions and a zero test.
package fp_pkg;

    typedef enum logic [1:0] {
        FP_ADD = 2'b00,
        FP_SUB = 2'b01,
        FP_MUL = 2'b10,
        FP_ILL = 2'b11
    } fp_op_e;

    // FP16 field positions
    localparam int FP_SIGN_BIT = 15;
    localparam int FP_EXP_HI   = 14;
    localparam int FP_EXP_LO   = 10;
    localparam int FP_MAN_HI   = 9;
    localparam int FP_MAN_LO   = 0;

    // Both signed zeroes; subnormals count as nonzero.
    function automatic logic fp16_is_zero(input logic [15:0] x);
        return (x[FP_EXP_HI:FP_MAN_LO] == 15'h0);
    endfunction

endpackage

// File: rtl/fp_req_fifo.sv
// Request FIFO: power-of-two depth, naturally wrapping pointers, occupancy count.
module fp_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 38
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           wdata_i,
    output logic [W-1:0]           rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO refuses pushes even if it pops in the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Occupancy next state; push+pop together leave it unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents are don't-care while not counted.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fp_issue_stage.sv
// FP16 issue stage: queues requests, drives the external ALU from the FIFO
// head (FSUB folded into FADD), bypasses zero-operand cases and registers
// results into a valid/ready output slot.
module fp_issue_stage
    import fp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15:0]            in_a,
    input  logic [15:0]            in_b,
    input  logic [1:0]             in_op,
    input  logic [TAG_W-1:0]       in_tag,
    output logic [15:0]            alu_a,
    output logic [15:0]            alu_b,
    output logic [1:0]             alu_op,
    input  logic [15:0]            alu_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_result,
    output logic                   out_zero,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   err_illegal,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int DW = 34 + TAG_W;

    logic [DW-1:0]    wdata, rdata;
    logic             full, empty, push, pop;
    logic             hd_vld, hd_ill, capture;
    logic [15:0]      hd_a, hd_b, pb;
    logic [1:0]       hd_op, op_n;
    logic [TAG_W-1:0] hd_tag;
    logic             az, bz;
    logic [15:0]      res_sel;

    logic             out_valid_q, out_valid_d;
    logic [15:0]      out_result_q;
    logic             out_zero_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             err_q;

    assign wdata = {in_a, in_b, in_op, in_tag};
    assign push  = in_valid && !full;
    assign in_ready = !full;

    fp_req_fifo #(.DEPTH(DEPTH), .W(DW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .count_o (occupancy)
    );

    assign hd_a   = rdata[DW-1 -: 16];
    assign hd_b   = rdata[DW-17 -: 16];
    assign hd_op  = rdata[TAG_W+1 -: 2];
    assign hd_tag = rdata[TAG_W-1:0];
    assign hd_vld = !empty;
    assign hd_ill = (hd_op == FP_ILL);

    // Head preprocessing: FSUB becomes FADD with B negated; the ALU never sees 01/11.
    always_comb begin
        pb   = hd_b;
        op_n = hd_op;
        if (hd_op == FP_SUB) begin
            pb[FP_SIGN_BIT] = ~hd_b[FP_SIGN_BIT];
            op_n = FP_ADD;
        end else if (hd_ill) begin
            op_n = FP_ADD;
        end
        alu_a  = hd_vld ? hd_a : 16'h0;
        alu_b  = hd_vld ? pb   : 16'h0;
        alu_op = hd_vld ? op_n : FP_ADD;
    end

    assign az = fp16_is_zero(hd_a);
    assign bz = fp16_is_zero(pb);

    // Zero-operand bypass: the ALU assumes a hidden 1, so zeroes are resolved here.
    always_comb begin
        res_sel = alu_result;
        if (hd_op == FP_MUL) begin
            if (az || bz) res_sel = {hd_a[FP_SIGN_BIT] ^ hd_b[FP_SIGN_BIT], 15'h0};
        end else begin
            if (az && bz)  res_sel = {hd_a[FP_SIGN_BIT] & pb[FP_SIGN_BIT], 15'h0};
            else if (az)   res_sel = pb;
            else if (bz)   res_sel = hd_a;
        end
    end

    // Illegal heads drop without waiting; legal heads need a free or draining slot.
    assign capture = hd_vld && !hd_ill && (!out_valid_q || out_ready);
    assign pop     = capture || (hd_vld && hd_ill);

    // Slot stays full on simultaneous drain+capture.
    always_comb begin
        out_valid_d = out_valid_q;
        if (capture)        out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
    end

    // Output slot and illegal-op pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= 16'h0;
            out_zero_q   <= 1'b0;
            out_tag_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            err_q       <= hd_vld && hd_ill;
            if (capture) begin
                out_result_q <= res_sel;
                out_zero_q   <= fp16_is_zero(res_sel);
                out_tag_q    <= hd_tag;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_zero    = out_zero_q;
    assign out_tag     = out_tag_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_fp_issue_stage.sv
// Directed bench for fp_issue_stage with a stub ALU (integer sum of operands,
// or a forced constant to expose bypass paths).
module tb_fp_issue_stage;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic                   clk, rst_n;
    logic                   in_valid, in_ready;
    logic [15:0]            in_a, in_b;
    logic [1:0]             in_op;
    logic [TAG_W-1:0]       in_tag;
    logic [15:0]            alu_a, alu_b, alu_result;
    logic [1:0]             alu_op;
    logic                   out_valid, out_ready, out_zero, err_illegal;
    logic [15:0]            out_result;
    logic [TAG_W-1:0]       out_tag;
    logic [$clog2(DEPTH):0] occupancy;
    logic                   force_stub;

    int vecs = 0;
    int errs = 0;

    fp_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_tag(out_tag),
        .err_illegal(err_illegal), .occupancy(occupancy)
    );

    assign alu_result = force_stub ? 16'h1234 : (alu_a + alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic [TAG_W-1:0] tag);
        in_valid = v; in_a = a; in_b = b; in_op = op; in_tag = tag;
    endtask

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, " in_ready"},    32'(in_ready),    32'h1);
        chk({pfx, " occupancy"},   32'(occupancy),   32'h0);
        chk({pfx, " out_valid"},   32'(out_valid),   32'h0);
        chk({pfx, " out_result"},  32'(out_result),  32'h0);
        chk({pfx, " out_zero"},    32'(out_zero),    32'h0);
        chk({pfx, " out_tag"},     32'(out_tag),     32'h0);
        chk({pfx, " err_illegal"}, 32'(err_illegal), 32'h0);
        chk({pfx, " alu_op"},      32'(alu_op),      32'h0);
        chk({pfx, " alu_a"},       32'(alu_a),       32'h0);
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b0; force_stub = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 2'b00, '0);
        #3;
        chk_reset("rst");
        #19 rst_n = 1'b1;
        step();

        // FSUB folded into FADD; stub sum 0x3C00 + 0xC000 = 0xFC00
        out_ready = 1'b1;
        drive(1'b1, 16'h3C00, 16'h4000, 2'b01, 4'd5);
        step();
        in_valid = 1'b0;
        chk("fsub alu_op", 32'(alu_op), 32'h0);
        chk("fsub alu_a", 32'(alu_a), 32'h3C00);
        chk("fsub alu_b", 32'(alu_b), 32'hC000);
        chk("fsub not yet valid", 32'(out_valid), 32'h0);
        chk("fsub occ", 32'(occupancy), 32'h1);
        step();
        chk("fsub out_valid", 32'(out_valid), 32'h1);
        chk("fsub result", 32'(out_result), 32'hFC00);
        chk("fsub tag", 32'(out_tag), 32'h5);
        chk("fsub zero", 32'(out_zero), 32'h0);
        step();
        chk("fsub drained", 32'(out_valid), 32'h0);

        // FMUL by zero bypasses the ALU
        force_stub = 1'b1;
        drive(1'b1, 16'h0000, 16'hC200, 2'b10, 4'd1);
        step(); in_valid = 1'b0; step();
        chk("fmul0 result", 32'(out_result), 32'h8000);
        chk("fmul0 zero", 32'(out_zero), 32'h1);
        chk("fmul0 tag", 32'(out_tag), 32'h1);
        step();
        force_stub = 1'b0;

        // FADD with A = -0 passes B through
        drive(1'b1, 16'h8000, 16'h4500, 2'b00, 4'd2);
        step(); in_valid = 1'b0; step();
        chk("fadd a0 result", 32'(out_result), 32'h4500);
        chk("fadd a0 zero", 32'(out_zero), 32'h0);
        step();

        // FSUB +0 - +0 = +0
        drive(1'b1, 16'h0000, 16'h0000, 2'b01, 4'd3);
        step(); in_valid = 1'b0; step();
        chk("fsub 00 result", 32'(out_result), 32'h0000);
        chk("fsub 00 zero", 32'(out_zero), 32'h1);
        step();

        // FADD -0 + -0 = -0
        drive(1'b1, 16'h8000, 16'h8000, 2'b00, 4'd4);
        step(); in_valid = 1'b0; step();
        chk("fadd nn result", 32'(out_result), 32'h8000);
        step();

        // FADD with B zero passes A
        drive(1'b1, 16'h4200, 16'h0000, 2'b00, 4'd6);
        step(); in_valid = 1'b0; step();
        chk("fadd b0 result", 32'(out_result), 32'h4200);
        step();

        // Illegal op between two FADDs
        drive(1'b1, 16'h3C00, 16'h3C00, 2'b00, 4'd7);
        step();
        drive(1'b1, 16'h1111, 16'h2222, 2'b11, 4'd8);
        chk("ill occ1", 32'(occupancy), 32'h1);
        step();
        chk("ill r1 valid", 32'(out_valid), 32'h1);
        chk("ill r1 tag", 32'(out_tag), 32'h7);
        chk("ill r1 result", 32'(out_result), 32'h7800);
        chk("ill err low", 32'(err_illegal), 32'h0);
        chk("ill head alu_op", 32'(alu_op), 32'h0);
        drive(1'b1, 16'h4000, 16'h4000, 2'b00, 4'd9);
        step();
        in_valid = 1'b0;
        chk("ill err pulse", 32'(err_illegal), 32'h1);
        chk("ill no output", 32'(out_valid), 32'h0);
        step();
        chk("ill err once", 32'(err_illegal), 32'h0);
        chk("ill r2 valid", 32'(out_valid), 32'h1);
        chk("ill r2 tag", 32'(out_tag), 32'h9);
        chk("ill r2 result", 32'(out_result), 32'h8000);
        chk("ill occ0", 32'(occupancy), 32'h0);
        step();
        chk("ill drained", 32'(out_valid), 32'h0);

        // Backpressure: hold slot full, fill FIFO, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 16'h3C00, 16'h0100, 2'b00, 4'd0);
        step(); in_valid = 1'b0; step();
        chk("bp slot held", 32'(out_valid), 32'h1);
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, 16'h3C00 + 16'(i), 16'h0100, 2'b00, TAG_W'(i));
            step();
        end
        chk("bp full occ", 32'(occupancy), 32'(DEPTH));
        chk("bp in_ready low", 32'(in_ready), 32'h0);
        drive(1'b1, 16'h3C00, 16'h0100, 2'b00, 4'd15);
        step();
        chk("bp extra refused", 32'(occupancy), 32'(DEPTH));
        chk("bp slot tag0", 32'(out_tag), 32'h0);
        chk("bp slot res0", 32'(out_result), 32'h3D00);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            step();
            chk("bp drain valid", 32'(out_valid), 32'h1);
            chk("bp drain tag", 32'(out_tag), 32'(k));
            chk("bp drain result", 32'(out_result), 32'h3D00 + 32'(k));
            chk("bp drain occ", 32'(occupancy), 32'(DEPTH - k));
        end
        step();
        chk("bp empty", 32'(out_valid), 32'h0);

        // Reset mid-stream with a held result and 3 queued entries
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h4400, 16'h0200, 2'b00, TAG_W'(10 + i));
            step();
        end
        in_valid = 1'b0;
        chk("mid held", 32'(out_valid), 32'h1);
        chk("mid occ3", 32'(occupancy), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        chk_reset("mid rst");
        #2 rst_n = 1'b1;
        step(); step();
        chk("post rst valid", 32'(out_valid), 32'h0);
        chk("post rst occ", 32'(occupancy), 32'h0);
        chk("post rst ready", 32'(in_ready), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
